// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared state type and sizing for the restoring divider
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIVIDEND_W_DEF = 8;
   localparam int DIVISOR_W_DEF  = 4;
   localparam int STEP_CNT_W_DEF = $clog2(DIVIDEND_W_DEF + 1);

   // Step counter must hold 0..DIVIDEND_W
   function automatic int step_cnt_w(input int dividend_w);
      return $clog2(dividend_w + 1);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/done handshake and result bundle for the divider
interface seq_restoring_divider_if
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
);

   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;
   logic                  check_err;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, check_err
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, check_err
   );

endinterface

// File: rtl/seq_restoring_divider_step.sv
// rtl/seq_restoring_divider_step.sv - one combinational restoring step: shift, trial subtract, select
module div_sub_step #(
   parameter int DIVISOR_W = 4
) (
   input  logic [DIVISOR_W:0]   partial,
   input  logic                 dividend_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   partial_next,
   output logic                 q_bit
);

   logic [DIVISOR_W:0]   shifted;
   logic [DIVISOR_W+1:0] trial;
   logic                 borrow;

   // Extra MSB on the trial difference acts as the borrow flag
   always_comb begin
      shifted      = {partial[DIVISOR_W-1:0], dividend_bit};
      trial        = {1'b0, shifted} - {2'b00, divisor};
      borrow       = trial[DIVISOR_W+1];
      q_bit        = ~borrow;
      partial_next = borrow ? shifted : trial[DIVISOR_W:0];
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential restoring divider top; optional DIV_SELFCHECK_EN multiply-back check
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input logic                    clk,
   input logic                    rst,
   seq_restoring_divider_if.slave bus
);

   localparam int CNT_W = step_cnt_w(DIVIDEND_W);

   div_state_t            state;
   div_state_t            state_next;
   logic                  busy;
   logic                  done;
   logic                  accept;
   logic                  last_step;

   logic [CNT_W-1:0]      count;
   logic [DIVISOR_W:0]    partial;
   logic [DIVISOR_W:0]    partial_next;
   logic                  q_bit;
   // Dividend bits shift out of the top while quotient bits shift in at the bottom
   logic [DIVIDEND_W-1:0] work;
   logic [DIVIDEND_W-1:0] q_next;
   logic [DIVISOR_W-1:0]  dvs;

   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;
   logic                  check_err;

   assign accept    = bus.start && ((state == IDLE) || (state == DONE));
   assign last_step = (state == CALC) && (count == CNT_W'(DIVIDEND_W - 1));
   assign q_next    = {work[DIVIDEND_W-2:0], q_bit};

   div_sub_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .partial      (partial),
      .dividend_bit (work[DIVIDEND_W-1]),
      .divisor      (dvs),
      .partial_next (partial_next),
      .q_bit        (q_bit)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status decode
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = (bus.divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (bus.start) begin
               state_next = (bus.divisor == '0) ? DONE : CALC;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         partial     <= '0;
         work        <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         if (bus.divisor != '0) begin
            work        <= bus.dividend;
            dvs         <= bus.divisor;
            partial     <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
         end else begin
            // Zero divisor skips CALC and publishes the fixed result at once
            quotient    <= '1;
            remainder   <= bus.dividend[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
         end
      end else if (state == CALC) begin
         partial <= partial_next;
         work    <= q_next;
         count   <= count + 1'b1;
         if (last_step) begin
            quotient  <= q_next;
            remainder <= partial_next[DIVISOR_W-1:0];
         end
      end
   end

`ifdef DIV_SELFCHECK_EN
   logic [DIVIDEND_W-1:0]           dvd_latched;
   logic [DIVIDEND_W+DIVISOR_W-1:0] prod;
   logic [DIVIDEND_W+DIVISOR_W-1:0] check_sum;

   // Keep the original dividend for the multiply-back comparison
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_latched <= '0;
      end else if (accept && (bus.divisor != '0)) begin
         dvd_latched <= bus.dividend;
      end
   end

   // Array multiplier: one shifted partial product row per divisor bit
   always_comb begin
      prod = '0;
      for (int i = 0; i < DIVISOR_W; i++) begin
         if (dvs[i]) begin
            prod = prod + ({{DIVISOR_W{1'b0}}, q_next} << i);
         end
      end
      check_sum = prod + {{DIVIDEND_W{1'b0}}, partial_next[DIVISOR_W-1:0]};
   end

   // Sticky error flag evaluated on the edge that enters DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         check_err <= 1'b0;
      end else if (last_step && (check_sum != {{DIVISOR_W{1'b0}}, dvd_latched})) begin
         check_err <= 1'b1;
      end
   end
`else
   assign check_err = 1'b0;
`endif

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.quotient    = quotient;
   assign bus.remainder   = remainder;
   assign bus.div_by_zero = div_by_zero;
   assign bus.check_err   = check_err;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - scoreboard bench for seq_restoring_divider
module tb_seq_restoring_divider;

   localparam int DW = 8;
   localparam int SW = 4;

   typedef struct {
      logic [DW-1:0] q;
      logic [SW-1:0] r;
      logic          dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   seq_restoring_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();

   seq_restoring_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: plain integer division, fixed pattern for a zero divisor
   function automatic void push_exp(input logic [DW-1:0] a, input logic [SW-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q   = {DW{1'b1}};
         e.r   = a[SW-1:0];
         e.dbz = 1'b1;
      end else begin
         e.q   = DW'(int'(a) / int'(b));
         e.r   = SW'(int'(a) % int'(b));
         e.dbz = 1'b0;
      end
      exp_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            mon_e = exp_q.pop_front();
            chk("quotient", bus.quotient, mon_e.q);
            chk("remainder", bus.remainder, mon_e.r);
            chk("div_by_zero", bus.div_by_zero, mon_e.dbz);
            chk("check_err", bus.check_err, 1'b0);
         end
      end
   end

   task automatic start_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input bit push);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      if (push) push_exp(a, b);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = DW'($urandom);
      bus.divisor  = SW'($urandom);
   endtask

   // Called at cycle 1; walks to the done cycle checking busy/done per cycle
   task automatic check_timing(input string tag, input int done_cyc, input int repulse_cyc);
      for (int c = 1; c <= done_cyc; c++) begin
         if (c > 1) @(negedge clk);
         bus.start = (c == repulse_cyc);
         if (c == repulse_cyc) begin
            bus.dividend = DW'($urandom);
            bus.divisor  = SW'($urandom_range(1, 15));
         end
         chk($sformatf("%s_busy_c%0d", tag, c), bus.busy, (c < done_cyc));
         chk($sformatf("%s_done_c%0d", tag, c), bus.done, (c == done_cyc));
      end
      bus.start = 1'b0;
   endtask

   task automatic wait_not_busy(input string tag);
      int w = 0;
      while (bus.busy && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=busy required=idle", tag);
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_quotient", bus.quotient, 0);
      chk("rst_remainder", bus.remainder, 0);
      chk("rst_dbz", bus.div_by_zero, 0);
      chk("rst_check_err", bus.check_err, 0);

      start_op(8'd200, 4'd7, 1);
      check_timing("t1", 9, 0);

      start_op(8'd255, 4'd15, 1);
      check_timing("t2a", 9, 0);
      start_op(8'd5, 4'd9, 1);
      check_timing("t2b", 9, 0);

      start_op(8'h5A, 4'd0, 1);
      check_timing("t3", 1, 0);

      start_op(8'd123, 4'd11, 1);
      check_timing("t4", 9, 4);

      // Abort mid-CALC
      start_op(8'd77, 4'd3, 0);
      for (int c = 2; c <= 5; c++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_busy", bus.busy, 0);
      chk("t5_done", bus.done, 0);
      chk("t5_quotient", bus.quotient, 0);
      chk("t5_remainder", bus.remainder, 0);
      chk("t5_dbz", bus.div_by_zero, 0);
      start_op(8'd77, 4'd3, 1);
      check_timing("t5_after", 9, 0);

      // Randomized operations with idle gaps, occasional zero divisor
      for (int n = 0; n < 200; n++) begin
         logic [DW-1:0] a;
         logic [SW-1:0] b;
         a = DW'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         wait_not_busy("rand");
         bus.start    = 1'b1;
         bus.dividend = a;
         bus.divisor  = b;
         push_exp(a, b);
         @(negedge clk);
         bus.start = 1'b0;
      end

      // Exhaustive back-to-back sweep with start held high
      wait_not_busy("pre_sweep");
      @(negedge clk);
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            wait_not_busy("sweep");
            bus.start    = 1'b1;
            bus.dividend = DW'(a);
            bus.divisor  = SW'(b);
            push_exp(DW'(a), SW'(b));
            @(negedge clk);
         end
      end
      bus.start = 1'b0;

      for (int w = 0; w < 30 && exp_q.size() > 0; w++) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("final_check_err", bus.check_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
